// File: rtl/cdec_dp_w.sv
// cdec_dp_w: parametrised CDEC data path.
// Registers PC/R/RDR/FLG/IPORT/MAR/WDR/T/I/OPORT/G0..G(NGPR-1), an XBUS source mux,
// a 16-op ALU with S/Z/C/V flags, and a handshaked memory port with wait-state timeout.
module cdec_dp_w #(
    parameter int WIDTH  = 8,
    parameter int NGPR   = 3,
    parameter int MEM_TO = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] adrs,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_ack,
    input  logic [4:0]       xsrc,
    input  logic [4:0]       xdst,
    input  logic [3:0]       aluop,
    input  logic             rwr,
    input  logic             fwr,
    input  logic [1:0]       mmrw,
    output logic [WIDTH-1:0] I,
    output logic [3:0]       SZCV,
    output logic             busy,
    input  logic [7:0]       resad,
    output logic [WIDTH-1:0] resdt
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_waitcnt;

    logic [WIDTH-1:0] r_pc, r_r, r_rdr, r_flg, r_iport, r_mar, r_wdr, r_t, r_i, r_oport;
    logic [WIDTH-1:0] r_g [NGPR];

    logic [WIDTH-1:0] w_xbus;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_alu;
    logic             w_c, w_v, w_s, w_z, w_cin;
    logic [WIDTH-1:0] w_flg_nxt;
    logic             w_wen, w_timeout, w_rd_done;

    // Writes from the control unit only land while no memory access is in flight.
    assign w_wen    = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign io_out   = r_oport;
    assign adrs     = r_mar;
    assign data_out = r_wdr;
    assign I        = r_i;
    assign SZCV     = r_flg[3:0];
    assign w_cin    = r_flg[1];

    // XBUS source mux; unassigned codes and missing general registers read all-ones.
    always_comb begin
        w_xbus = '1;
        case (xsrc)
            5'd0:    w_xbus = r_pc;
            5'd1:    w_xbus = r_r;
            5'd2:    w_xbus = r_rdr;
            5'd3:    w_xbus = r_flg;
            5'd4:    w_xbus = r_iport;
            default: w_xbus = '1;
        endcase
        for (int k = 0; k < NGPR; k++) begin
            if (xsrc == 5'(8 + k)) w_xbus = r_g[k];
        end
    end

    // ALU: x is XBUS, y is T, carry-in is FLG.C; C is carry for adds, borrow for subtracts.
    always_comb begin
        w_ext = '0;
        w_alu = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (aluop)
            4'h0, 4'h1: begin
                w_ext = {1'b0, w_xbus} + {1'b0, r_t} + {{WIDTH{1'b0}}, (aluop[0] & w_cin)};
                w_alu = w_ext[MSB:0];
                w_c   = w_ext[WIDTH];
                w_v   = (w_xbus[MSB] == r_t[MSB]) && (w_alu[MSB] != w_xbus[MSB]);
            end
            4'h2, 4'h3: begin
                w_ext = {1'b0, w_xbus} - {1'b0, r_t} - {{WIDTH{1'b0}}, (aluop[0] & w_cin)};
                w_alu = w_ext[MSB:0];
                w_c   = w_ext[WIDTH];
                w_v   = (w_xbus[MSB] != r_t[MSB]) && (w_alu[MSB] != w_xbus[MSB]);
            end
            4'h4: w_alu = w_xbus & r_t;
            4'h5: w_alu = w_xbus | r_t;
            4'h6: w_alu = w_xbus ^ r_t;
            4'h7: w_alu = ~w_xbus;
            4'h8: begin
                w_alu = {w_xbus[MSB-1:0], 1'b0};
                w_c   = w_xbus[MSB];
            end
            4'h9: begin
                w_alu = {1'b0, w_xbus[MSB:1]};
                w_c   = w_xbus[0];
            end
            4'hA: begin
                w_alu = {w_xbus[MSB-1:0], w_cin};
                w_c   = w_xbus[MSB];
            end
            4'hB: begin
                w_alu = {w_cin, w_xbus[MSB:1]};
                w_c   = w_xbus[0];
            end
            4'hC: begin
                w_ext = {1'b0, w_xbus} + {{WIDTH{1'b0}}, 1'b1};
                w_alu = w_ext[MSB:0];
                w_c   = w_ext[WIDTH];
                w_v   = !w_xbus[MSB] && w_alu[MSB];
            end
            4'hD: begin
                w_ext = {1'b0, w_xbus} - {{WIDTH{1'b0}}, 1'b1};
                w_alu = w_ext[MSB:0];
                w_c   = w_ext[WIDTH];
                w_v   = w_xbus[MSB] && !w_alu[MSB];
            end
            4'hE: w_alu = w_xbus;
            4'hF: w_alu = r_t;
        endcase
    end

    assign w_s = w_alu[MSB];
    assign w_z = (w_alu == '0);

    // Memory handshake FSM: next state, request levels and completion/timeout strobes.
    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        w_rd_done   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mmrw == 2'b10)      w_state_nxt = ST_RD;
                else if (mmrw == 2'b01) w_state_nxt = ST_WR;
            end
            ST_RD: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_waitcnt == 8'(MEM_TO)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                mem_wr = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_waitcnt == 8'(MEM_TO)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and wait counter; the counter reads 1 in the first RD/WR cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_waitcnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_waitcnt <= (w_state_nxt == ST_IDLE) ? 8'd0 : r_waitcnt + 8'd1;
        end
    end

    // FLG next value: fwr beats an XBUS load on bits 3:0, a timeout sets ERR.
    always_comb begin
        w_flg_nxt = r_flg;
        if (w_wen && xdst == 5'd6) begin
            w_flg_nxt        = '0;
            w_flg_nxt[3:0]   = w_xbus[3:0];
            w_flg_nxt[MSB]   = w_xbus[MSB];
        end
        if (w_wen && fwr) w_flg_nxt[3:0] = {w_s, w_z, w_c, w_v};
        if (w_timeout)    w_flg_nxt[MSB] = 1'b1;
    end

    // Architectural registers: XBUS destinations, R from the ALU, RDR from memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= '0;
            r_r     <= '0;
            r_rdr   <= '0;
            r_flg   <= '0;
            r_iport <= '0;
            r_mar   <= '0;
            r_wdr   <= '0;
            r_t     <= '0;
            r_i     <= '0;
            r_oport <= '0;
            for (int k = 0; k < NGPR; k++) r_g[k] <= '0;
        end else begin
            r_iport <= io_in;
            r_flg   <= w_flg_nxt;
            if (w_rd_done) r_rdr <= data_in;
            if (w_wen) begin
                case (xdst)
                    5'd0:    r_pc    <= w_xbus;
                    5'd1:    r_mar   <= w_xbus;
                    5'd2:    r_wdr   <= w_xbus;
                    5'd3:    r_t     <= w_xbus;
                    5'd4:    r_i     <= w_xbus;
                    5'd5:    r_oport <= w_xbus;
                    default: begin end
                endcase
                for (int k = 0; k < NGPR; k++) begin
                    if (xdst == 5'(8 + k)) r_g[k] <= w_xbus;
                end
                if (rwr) r_r <= w_alu;
            end
        end
    end

    // Debug monitor read mux; G0..G2 also appear at their legacy 08..0A addresses.
    always_comb begin
        resdt = '0;
        case (resad)
            8'h00:   resdt = r_pc;
            8'h01:   resdt = r_i;
            8'h02:   resdt = r_t;
            8'h03:   resdt = r_r;
            8'h04:   resdt = r_mar;
            8'h05:   resdt = data_in;
            8'h06:   resdt = r_rdr;
            8'h07:   resdt = r_wdr;
            8'h0D:   resdt = r_flg;
            8'h0E:   resdt = w_xbus;
            8'h0F:   resdt = r_iport;
            default: resdt = '0;
        endcase
        for (int k = 0; k < NGPR; k++) begin
            if (k < 3 && resad == 8'(8 + k)) resdt = r_g[k];
            if (resad == 8'(16 + k))         resdt = r_g[k];
        end
    end

endmodule

// File: doc/cdec_dp_w.md
# cdec_dp_w

Parametrised successor of the CDEC 8-bit data path: a WIDTH-bit register/ALU/XBUS data path with NGPR general registers, a built-in ALU with overflow flag, and a handshaked memory port with wait states and timeout. It sits between the CDEC control unit, which drives the decoded control fields and stalls on `busy`, and the memory/IO/debug-monitor buses at the top level.

## Interface

- WIDTH, 8: data/address width (8..32).
- NGPR, 3: number of general registers G0..G(NGPR-1) (1..8).
- MEM_TO, 15: max wait cycles for `mem_ack` before abort (1..255).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- io_in  in  WIDTH  input port.
- io_out  out  WIDTH  output port register (OPORT).
- adrs  out  WIDTH  memory address, equals MAR.
- data_in  in  WIDTH  memory read data.
- data_out  out  WIDTH  memory write data, equals WDR.
- mem_rd  out  1  read request, level.
- mem_wr  out  1  write request, level.
- mem_ack  in  1  memory completion strobe.
- xsrc  in  5  XBUS source select.
- xdst  in  5  XBUS destination select.
- aluop  in  4  ALU operation.
- rwr  in  1  load R from ALU.
- fwr  in  1  load S/Z/C/V from ALU.
- mmrw  in  2  10 = read, 01 = write, 00/11 = none.
- I  out  WIDTH  instruction register.
- SZCV  out  4  FLG[3:0].
- busy  out  1  memory access in progress; control unit must stall.
- resad  in  8  debug resource address.
- resdt  out  WIDTH  debug resource data, pure mux, no tri-state.

## Operation

- xsrc: 0 PC, 1 R, 2 RDR, 3 FLG, 4 IPORT, 8+k Gk (k<NGPR); any other code returns all-ones.
- xdst: 0 PC, 1 MAR, 2 WDR, 3 T, 4 I, 5 OPORT, 6 FLG, 8+k Gk; any other code writes nothing.
- ALU: x = XBUS, y = T, cin = FLG[1]. Ops:
  - 0 ADD, 1 ADC, 2 SUB (x-y), 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT x, 8 SHL, 9 SHR, A ROL through C, B ROR through C, C INC x, D DEC x, E PASS x, F PASS y.
- Flags:
  - S = result MSB; Z = result==0.
  - C = carry out (add), borrow (sub), or shifted-out bit; logic ops clear C.
  - V = two's-complement overflow for ADD/ADC/SUB/SBC/INC/DEC, else 0.
- FLG layout: bit0 V, bit1 C, bit2 Z, bit3 S, bit WIDTH-1 ERR, all other bits 0.
  - `fwr` updates bits 3:0 only and takes priority over xdst=6 for those bits.
  - An xdst=6 write loads bits 3:0 and ERR from XBUS.
- IPORT samples io_in every cycle.
- Memory FSM states:
  - IDLE: when mmrw=10 go to RD; when mmrw=01 go to WR.
  - RD: mem_rd=1. On mem_ack, RDR<=data_in and return to IDLE. If waitcnt reaches MEM_TO with no ack, set ERR, leave RDR unchanged, return to IDLE.
  - WR: mem_wr=1. On mem_ack return to IDLE. If waitcnt reaches MEM_TO with no ack, set ERR and return to IDLE.
- busy = (state != IDLE).
- While busy, all register writes are suppressed (xdst, rwr, fwr) and mmrw is ignored. The ERR set on timeout and the RDR load on read completion are the only exceptions.
- mem_ack while IDLE is ignored.
- resad: 00 PC, 01 I, 02 T, 03 R, 04 MAR, 05 data_in, 06 RDR, 07 WDR, 08..0A G0..G2, 0B..0C zero (external), 0D FLG, 0E XBUS, 0F IPORT, 10+k Gk; else 0.

## Timing

- All registers update on the rising edge of clock; XBUS, ALU and resdt are combinational.
- Reset (synchronous): every register including IPORT and io_out is 0, FSM is IDLE, waitcnt is 0, mem_rd/mem_wr/busy are 0.
  - Reset mid-access drops the request the next cycle. No RDR load and no ERR.
- Any register write is visible on XBUS in the next cycle.
- Same-cycle xdst=T and rwr: the ALU uses the old T.
- Request timing:
  - mmrw sampled in IDLE → mem_rd/mem_wr high from the next cycle.
  - Minimum access is 2 cycles (request cycle plus ack cycle).
  - busy falls in the cycle after ack.
- waitcnt counts cycles in RD/WR starting at 1. Timeout fires on the edge where waitcnt == MEM_TO and ack is low.
  - Ack arriving in the same cycle as the timeout wins: normal completion, no ERR.
- adrs/data_out are stable for the whole access because MAR/WDR writes are blocked while busy.
- IPORT has 1-cycle latency from io_in.

## Test plan

- Reset: drive data through the bus for 5 cycles, then assert reset 1 cycle → all resdt addresses read 0, busy=0, io_out=0.
- ALU overflow (WIDTH=8): T=0x7F, G0=0x01, xsrc=G0, aluop=ADD, rwr=fwr=1 → R=0x80, SZCV=1001. Then SUB 0x00-0x01 → R=0xFF, C=1, V=0.
- Read with 3-cycle wait: MAR=0x40, mmrw=10, ack on the 3rd RD cycle with data_in=0x5A → busy for exactly 3 cycles, RDR=0x5A, ERR=0. An xdst=A write attempted during busy is suppressed.
- Timeout (MEM_TO=4): write request, ack never asserted → mem_wr high 4 cycles, then FLG=0x80. Writing FLG=0 via xdst=6 clears ERR.
- Ack/timeout collision: ack in the same cycle waitcnt==MEM_TO → ERR stays 0 and RDR loads.
- Parameters WIDTH=16, NGPR=4: write G3=0xBEEF via xdst=11 and read back via xsrc=11 and resad=0x13 → 0xBEEF. xsrc=12 → 0xFFFF.
